// File: rtl/glyph_pkg.sv
// Shared constants and state encoding for the glyph ROM row packer.
package glyph_pkg;

  localparam int unsigned GLYPH_W = 8;   // pixels per row
  localparam int unsigned GLYPH_H = 16;  // rows per glyph
  localparam int unsigned ADDR_W  = 7;   // log2(GLYPH_W * GLYPH_H)
  localparam int unsigned ROW_W   = 4;   // log2(GLYPH_H)
  localparam int unsigned COL_W   = 3;   // log2(GLYPH_W)

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    EMIT,
    DONE
  } state_e;

endpackage

// File: rtl/glyph_row_shift.sv
// Serial-in / parallel-out register: shifts left with din entering at bit 0,
// so the first bit captured ends up in the MSB after Width captures.
module glyph_row_shift #(
  parameter int unsigned Width = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] shift_q;

  // Clear has priority; otherwise shift in one bit per enabled cycle.
  always_ff @(posedge clock) begin
    if (clear) begin
      shift_q <= '0;
    end else if (enable) begin
      shift_q <= {shift_q[Width-2:0], din};
    end
  end

  assign dout = shift_q;

endmodule

// File: rtl/glyph_row_packer.sv
// Scans a 1-bit 8x16 glyph ROM in row-major order and hands each row
// downstream as a packed byte over a valid/ready handshake.
module glyph_row_packer
  import glyph_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic               rom_q,
  output logic [GLYPH_W-1:0] row_data,
  output logic [ROW_W-1:0]   row_index,
  output logic               row_valid,
  input  logic               row_ready,
  output logic               done
);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  // ROM q lags the address by one cycle, so capture trails FETCH by one.
  logic             cap_q;

  // State, counters and capture-enable registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cap_q   <= (state_q == FETCH);
    end
  end

  // Next-state, counter updates and all control outputs.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    busy        = 1'b0;
    rom_address = '0;
    row_valid   = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
        end
      end
      FETCH: begin
        busy        = 1'b1;
        rom_address = {row_q, col_q};
        col_d       = col_q + COL_W'(1);
        if (col_q == COL_W'(GLYPH_W - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        row_valid = 1'b1;
        if (row_ready) begin
          if (row_q == ROW_W'(GLYPH_H - 1)) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            row_d   = row_q + ROW_W'(1);
            col_d   = '0;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign row_index = row_q;

  glyph_row_shift #(
    .Width (GLYPH_W)
  ) u_shift (
    .clock  (clock),
    .clear  (reset),
    .enable (cap_q),
    .din    (rom_q),
    .dout   (row_data)
  );

endmodule

// File: tb/tb_glyph_row_packer.sv
// Self-checking bench for glyph_row_packer: bench-side ROM, a timeline model
// of the scan, a per-cycle compare process and literal expectations.
module tb_glyph_row_packer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy;
  logic [6:0] rom_address;
  logic       rom_q = 1'b0;
  logic [7:0] row_data;
  logic [3:0] row_index;
  logic       row_valid;
  logic       row_ready = 1'b1;
  logic       done;

  glyph_row_packer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .row_data    (row_data),
    .row_index   (row_index),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .done        (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench ROM: registered output, one cycle of read latency.
  logic rom [128];
  always @(posedge clock) rom_q <= rom[rom_address];

  function automatic logic [7:0] exp_row(input int r);
    logic [7:0] b;
    for (int c = 0; c < 8; c++) b[7-c] = rom[r*8+c];
    return b;
  endfunction

  task automatic load_bytes(input logic [7:0] rows [16]);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 8; c++) rom[r*8+c] = rows[r][7-c];
  endtask

  // Scan timeline model: mode 0 idle, 1 scanning, 2 done-pulse cycle.
  // In a row, phases 0..7 read col 0..7, phase 8 is the drain gap, 9 offers the byte.
  int m_mode = 0;
  int m_row  = 0;
  int m_ph   = 0;
  bit chk_en = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_mode = 0; m_row = 0; m_ph = 0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_row = 0; m_ph = 0; end
        1: begin
          if (m_ph < 9) m_ph++;
          else if (row_ready) begin
            if (m_row == 15) m_mode = 2;
            else begin m_row++; m_ph = 0; end
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  logic [7:0] beat_data [32];
  logic [3:0] beat_idx  [32];
  int beat_cnt = 0;

  // Compare DUT against the model every cycle, and log accepted beats.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", busy, (m_mode != 0));
      chk("rom_address", rom_address, (m_mode == 1 && m_ph < 8) ? 32'(m_row*8 + m_ph) : 0);
      chk("row_valid", row_valid, (m_mode == 1 && m_ph == 9));
      chk("done", done, (m_mode == 2));
      if (m_mode == 1 && m_ph == 9) begin
        chk("row_index", row_index, m_row);
        chk("row_data", row_data, exp_row(m_row));
      end
      if (row_valid && row_ready && beat_cnt < 32) begin
        beat_data[beat_cnt] = row_data;
        beat_idx[beat_cnt]  = row_index;
        beat_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Starts a scan (also releasing reset) and runs it to the done pulse.
  task automatic run_scan(input int stall_row, input bit rand_ready, input bit poke,
                          output int cyc);
    int  stalls = 0;
    bit  poked  = 1'b0;
    beat_cnt  = 0;
    row_ready = 1'b1;
    reset     = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < 2000) begin
      start = 1'b0;
      if (rand_ready) begin
        row_ready = ($urandom_range(0, 3) != 0);
      end else if (stall_row >= 0 && row_valid && row_index == 4'(stall_row) && stalls < 5) begin
        row_ready = 1'b0;
        stalls++;
        chk("stall_data", row_data, 8'h3C);
        chk("stall_addr", rom_address, 0);
      end else begin
        row_ready = 1'b1;
      end
      if (poke && !poked && busy && row_index == 4'd7) begin
        start = 1'b1;
        poked = 1'b1;
      end
      if (rand_ready && $urandom_range(0, 15) == 0) start = 1'b1;
      step();
      cyc++;
    end
    if (!done) chk("done_timeout", 0, 1);
    start = poke;  // a start in the done cycle must be ignored
    step();
    start     = 1'b0;
    row_ready = 1'b1;
  endtask

  task automatic check_beats(input string tag, input logic [7:0] lit [16]);
    chk({tag, "_beats"}, beat_cnt, 16);
    for (int i = 0; i < 16 && i < beat_cnt; i++) begin
      chk({tag, "_idx"}, beat_idx[i], i);
      chk({tag, "_byte"}, beat_data[i], lit[i]);
    end
  endtask

  logic [7:0] digit3 [16];
  logic [7:0] zeros  [16];
  logic [7:0] pix    [16];
  int cyc;
  int waited;
  int done_seen;

  initial begin
    digit3 = '{8'h00, 8'h00, 8'h00, 8'h3C, 8'h6E, 8'h6E, 8'h0C, 8'h1C,
               8'h0E, 8'hEE, 8'hEE, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00};
    foreach (zeros[i]) zeros[i] = 8'h00;
    load_bytes(digit3);

    // Reset state
    reset = 1'b1;
    step(); step(); step();
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", row_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_address, 0);
    chk("rst_data", row_data, 0);
    chk("rst_index", row_index, 0);

    // Plain scan, ready tied high, start in the reset-release cycle
    run_scan(-1, 1'b0, 1'b0, cyc);
    chk("done_cycle", cyc, 161);
    check_beats("digit3", digit3);

    // Backpressure at row 3 plus ignored starts mid-scan and in DONE
    step();
    run_scan(3, 1'b0, 1'b1, cyc);
    chk("stall_done_cycle", cyc, 166);
    check_beats("stall", digit3);

    // Reset during row 9 FETCH
    step();
    start = 1'b1; step(); start = 1'b0;
    waited = 0;
    while (rom_address != 7'd74 && waited < 400) begin step(); waited++; end
    chk("reach_row9", rom_address, 74);
    reset = 1'b1; step(); reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", row_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", rom_address, 0);
    chk("abort_data", row_data, 0);
    chk("abort_index", row_index, 0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || row_valid) done_seen++;
      step();
    end
    chk("abort_quiet", done_seen, 0);
    reset = 1'b1; step();
    run_scan(-1, 1'b0, 1'b0, cyc);
    chk("rescan_cycle", cyc, 161);
    check_beats("rescan", digit3);

    // Single pixel at address 0, then at address 127
    foreach (rom[i]) rom[i] = 1'b0;
    rom[0] = 1'b1;
    pix = zeros; pix[0] = 8'h80;
    step();
    run_scan(-1, 1'b0, 1'b0, cyc);
    check_beats("pix0", pix);
    rom[0] = 1'b0; rom[127] = 1'b1;
    pix = zeros; pix[15] = 8'h01;
    step();
    run_scan(-1, 1'b0, 1'b0, cyc);
    check_beats("pix127", pix);

    // Random ROM contents with random backpressure and stray starts
    for (int n = 0; n < 4; n++) begin
      foreach (rom[i]) rom[i] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) pix[i] = exp_row(i);
      step();
      run_scan(-1, 1'b1, 1'b0, cyc);
      check_beats("rand", pix);
      repeat (3) step();
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
